// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 datapath mux among four requesters.
// Latency: grant one cycle after a request seen in IDLE; beats pass combinationally while BUSY.
// Backpressure: out_ready low stalls the granted beat; the grant holds with no timeout.
module mux_rr_arbiter #(
  parameter int DW       = 8,
  parameter int HOLD_MAX = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req,
  input  logic [3:0]      last,
  input  logic [4*DW-1:0] din,
  output logic [3:0]      gnt,
  output logic [1:0]      sel,
  output logic            busy,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  input  logic            out_ready
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  sel_q, sel_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        win_vld;
  logic [1:0]  win_idx;
  logic [1:0]  cand;

  logic [DW-1:0] mux_dat;
  logic        sel_req;
  logic        sel_last;
  logic        in_busy;
  logic        xfer;
  logic        burst_end;
  logic        hold_hit;
  logic        withdraw;
  logic        rel;

  // Circular search from ptr: iterate offsets high to low so the smallest offset wins
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    cand    = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Shared datapath mux and release decode for the currently granted requester
  always_comb begin
    mux_dat   = din[sel_q*DW +: DW];
    sel_req   = req[sel_q];
    sel_last  = last[sel_q];
    in_busy   = (state_q == ST_BUSY);
    xfer      = in_busy & sel_req & out_ready;
    burst_end = xfer & sel_last;
    hold_hit  = xfer & ((cnt_q + 8'd1) == HOLD_MAX_C);
    // No transfer is possible when req[sel] is low, so withdrawal needs no extra qualifier
    withdraw  = in_busy & ~sel_req;
    rel       = burst_end | hold_hit | withdraw;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: IDLE grants any pending request; BUSY returns to IDLE on release
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (win_vld) state_d = ST_BUSY;
      ST_BUSY: if (rel)     state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: the downstream port only shows the granted channel while BUSY
  always_comb begin
    busy      = in_busy;
    out_valid = in_busy & sel_req;
    out_last  = in_busy & sel_req & sel_last;
    out_data  = in_busy ? mux_dat : '0;
  end

  // Grant/pointer/counter next values; sel deliberately keeps its value across release
  always_comb begin
    ptr_d = ptr_q;
    sel_d = sel_q;
    gnt_d = gnt_q;
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) begin
      if (win_vld) begin
        gnt_d = 4'b0001 << win_idx;
        sel_d = win_idx;
        cnt_d = 8'd0;
      end
    end else if (rel) begin
      gnt_d = 4'b0000;
      ptr_d = sel_q + 2'd1;
      cnt_d = 8'd0;
    end else if (xfer) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Grant/pointer/counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 2'd0;
      sel_q <= 2'd0;
      gnt_q <= 4'b0000;
      cnt_q <= 8'd0;
    end else begin
      ptr_q <= ptr_d;
      sel_q <= sel_d;
      gnt_q <= gnt_d;
      cnt_q <= cnt_d;
    end
  end

  assign gnt = gnt_q;
  assign sel = sel_q;

endmodule
